nios_system_nios2_processor_mulx_unit: RTL and testbench
========================================================

Name: nios_system_nios2_processor_mulx_unit

Overview:
Multi-cycle high-word multiplier placed beside the processor's 32-bit low-word multiply cell. It consumes the same A-stage source operands and returns bits [63:32] of the 64-bit product for mulxuu, mulxsu, mulxss and mulxus. It uses one registered 16x16 unsigned multiplier, time-shared over four partial products, under a start/busy/done handshake. The pipeline stalls on busy and writes back result_hi when done pulses.

Parameters:
WIDTH, 32, operand width; only 32 is supported; HALF = WIDTH/2 is derived internally.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
src1  input  32  multiplicand
src2  input  32  multiplier
op  input  2  op[0]=src1 signed, op[1]=src2 signed (00 uu, 01 su, 10 us, 11 ss)
busy  output  1  high from the cycle after start is accepted until the done cycle, exclusive
done  output  1  one-cycle pulse; result_hi valid
result_hi  output  32  product bits [63:32]; held until next done

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; result_hi=0; all internal registers=0.
- States: IDLE -> LOAD -> MUL -> FIX -> IDLE.
- IDLE: start=1 captures src1, src2, op; sets busy=1; go to LOAD.
- LOAD: register magnitudes.
  - mag1 = (op[0] && src1[31]) ? -src1 : src1, as 32-bit unsigned. 0x80000000 gives magnitude 0x80000000.
  - mag2 likewise using op[1] and src2.
  - neg = (op[0]&src1[31]) ^ (op[1]&src2[31]).
  - Clear the 64-bit accumulator and cnt; go to MUL.
- MUL:
  - cnt 0..3 issues partial products (lo1*lo2, hi1*lo2, lo1*hi2, hi1*hi2) to the registered multiplier, which has 1-cycle latency.
  - Each partial product is added to the accumulator the cycle after issue, shifted by 0, 16, 16 and 32 respectively.
  - Full 64-bit add; no overflow is possible for unsigned magnitudes.
  - After the 4th accumulate, go to FIX.
- FIX:
  - result_hi <= neg ? (-acc)[63:32] : acc[63:32], two's complement over all 64 bits.
  - done=1 and busy=0 for this cycle; return to IDLE.
- Latency: done is high in the 8th cycle after the cycle in which start was sampled high (fixed, data-independent).
- start while busy=1 is ignored, with no queuing.
- start in the done cycle is not accepted; the earliest next accept is the cycle after done.
- The src and op inputs may change freely after acceptance; the captured copies are used.
- Reset asserted mid-operation aborts it: no done pulse, and result_hi returns to 0.

Optional Feature:
MULX_ZERO_SKIP_EN
- Defined: in LOAD, if mag1==0 or mag2==0, skip MUL and FIX and assert done with result_hi=0 on the next cycle. Latency becomes 3 cycles; busy drops with done.
- Undefined: no zero detection; zero operands take the full 8-cycle path, giving result 0.

Test Plan:
1. uu, src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result_hi=0xFFFFFFFE; done exactly 8 cycles after start; busy high 7 cycles.
2. ss, 0x80000000 x 0x80000000 -> result_hi=0x40000000. ss, 0xFFFFFFFF x 0x00000001 -> 0xFFFFFFFF. Same operands as uu -> 0x00000000.
3. su, 0xFFFFFFFE x 0x80000000 -> result_hi=0xFFFFFFFF. us, 0x80000000 x 0xFFFFFFFF -> 0xFFFFFFFF. uu, 0x12345678 x 0x9ABCDEF0 -> 0x0B00EA4E.
4. Handshake sequence, then check the result:
   - second start 3 cycles into an operation is ignored, giving exactly one done;
   - start in the done cycle is ignored;
   - start the following cycle is accepted.
   Then uu, 0x00010000 x 0x00010000 -> result_hi=0x00000001.
5. Reset pulse at cycle 4 of an operation -> busy=0, done never pulses, result_hi=0. A new start after reset completes normally.
6. uu, 0x00000000 x 0x12345678 -> result_hi=0. Done at 8 cycles with MULX_ZERO_SKIP_EN undefined; at 3 cycles with it defined.

Source files
------------

// File: rtl/nios_system_nios2_processor_mulx_unit.sv
// High-word (bits [63:32]) multiplier for mulxuu/mulxsu/mulxss/mulxus using one
// registered 16x16 multiplier over four partial products. Optional: MULX_ZERO_SKIP_EN.
module nios_system_nios2_processor_mulx_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, LOAD, MUL, FIX} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     src1_reg, src2_reg;
  logic [1:0]           op_reg;
  logic [WIDTH-1:0]     mag1_reg, mag2_reg;
  logic                 neg_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2:0]           cnt_reg;
  logic [WIDTH-1:0]     prod_reg;
  logic [5:0]           shift_reg;
  logic [WIDTH-1:0]     result_reg;

  logic [HALF-1:0]      mul_a, mul_b;
  logic [5:0]           shift_now;
  logic [2*WIDTH-1:0]   acc_neg;
  logic                 src1_neg, src2_neg;
  logic                 mag_zero;

  assign src1_neg = op_reg[0] & src1_reg[WIDTH-1];
  assign src2_neg = op_reg[1] & src2_reg[WIDTH-1];
  assign mag_zero = (mag1_reg == '0) || (mag2_reg == '0);
  assign acc_neg  = -acc_reg;

  // cnt 0..3 selects lo1*lo2, hi1*lo2, lo1*hi2, hi1*hi2
  always_comb begin
    mul_a     = cnt_reg[0] ? mag1_reg[WIDTH-1:HALF] : mag1_reg[HALF-1:0];
    mul_b     = cnt_reg[1] ? mag2_reg[WIDTH-1:HALF] : mag2_reg[HALF-1:0];
    shift_now = 6'd16;
    if (cnt_reg == 3'd0)
      shift_now = 6'd0;
    else if (cnt_reg == 3'd3)
      shift_now = 6'd32;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = MUL;
      MUL: begin
`ifdef MULX_ZERO_SKIP_EN
        if (cnt_reg == 3'd0 && mag_zero)
          state_next = FIX;
`endif
        // cnt 5 is the cycle after the last accumulate; acc is final here
        if (cnt_reg == 3'd5)
          state_next = FIX;
      end
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1_reg   <= '0;
      src2_reg   <= '0;
      op_reg     <= '0;
      mag1_reg   <= '0;
      mag2_reg   <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      prod_reg   <= '0;
      shift_reg  <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            src1_reg <= src1;
            src2_reg <= src2;
            op_reg   <= op;
          end
        end
        LOAD: begin
          mag1_reg <= src1_neg ? -src1_reg : src1_reg;
          mag2_reg <= src2_neg ? -src2_reg : src2_reg;
          neg_reg  <= src1_neg ^ src2_neg;
          acc_reg  <= '0;
          cnt_reg  <= '0;
        end
        MUL: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg < 3'd4) begin
            prod_reg  <= mul_a * mul_b;
            shift_reg <= shift_now;
          end
          if (cnt_reg >= 3'd1 && cnt_reg <= 3'd4)
            acc_reg <= acc_reg + ({{WIDTH{1'b0}}, prod_reg} << shift_reg);
          if (cnt_reg == 3'd5)
            result_reg <= neg_reg ? acc_neg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
`ifdef MULX_ZERO_SKIP_EN
          if (cnt_reg == 3'd0 && mag_zero)
            result_reg <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg == LOAD) || (state_reg == MUL);
  assign done      = (state_reg == FIX);
  assign result_hi = result_reg;

endmodule

// File: tb/tb_nios_system_nios2_processor_mulx_unit.sv
// Randomized self-checking bench for the mulx high-word unit against a 64-bit
// arithmetic reference product.
module tb_nios_system_nios2_processor_mulx_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src1, src2;
  logic [1:0]  op;
  logic        busy, done;
  logic [31:0] result_hi;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  nios_system_nios2_processor_mulx_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .src1(src1), .src2(src2),
    .op(op), .busy(busy), .done(done), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_hi(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = o[0] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = o[1] ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return p[63:32];
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULX_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 3;
`endif
    return 8;
  endfunction

  // Issue one op; count cycles to done (1 = cycle after start sampled) and busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n, nbusy;
    logic [31:0] exp;
    exp = ref_hi(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom; op = 2'($urandom_range(0, 3));
    n = 1; nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " result"}, 64'(result_hi), 64'(exp));
    chk({tag, " latency"}, 64'(n), 64'(ref_lat(a, b)));
    chk({tag, " busy_cycles"}, 64'(nbusy), 64'(ref_lat(a, b) - 1));
    chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    $display("op=%0d src1=%08h src2=%08h -> result_hi=%08h (exp %08h) lat=%0d", o, a, b, result_hi, exp, n);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " held"}, 64'(result_hi), 64'(exp));
  endtask

  initial begin
    int n, ndone;
    logic [31:0] a, b, exp;
    logic [1:0]  o;

    reset = 1'b1; start = 1'b0; src1 = '0; src2 = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result_hi), 64'd0);
    @(negedge clk); reset = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "uu_max");
    run_op(2'b11, 32'h80000000, 32'h80000000, "ss_min");
    run_op(2'b11, 32'hFFFFFFFF, 32'h00000001, "ss_m1x1");
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000001, "uu_m1x1");
    run_op(2'b01, 32'hFFFFFFFE, 32'h80000000, "su");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "us");
    run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, "uu_pat");
    run_op(2'b00, 32'h00000000, 32'h12345678, "uu_zero");
    run_op(2'b11, 32'h12345678, 32'h00000000, "ss_zero");

    // Handshake: mid-op start ignored, start in done cycle ignored, next cycle accepted
    a = 32'hDEADBEEF; b = 32'h01234567; exp = ref_hi(2'b00, a, b);
    @(negedge clk);
    start = 1'b1; op = 2'b00; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; ndone = 0;
    while (!done && n < 20) begin
      if (n == 3) begin start = 1'b1; src1 = $urandom; src2 = $urandom; end
      else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("hs first latency", 64'(n), 64'd8);
    chk("hs first result", 64'(result_hi), 64'(exp));
    start = 1'b1; op = 2'b00; src1 = 32'h00010000; src2 = 32'h00010000;
    @(posedge clk); #1;
    chk("hs done-cycle start ignored", 64'(busy), 64'd0);
    chk("hs no second done", 64'(done), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom;
    chk("hs next-cycle accepted", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hs second latency", 64'(n), 64'd8);
    chk("hs second result", 64'(result_hi), 64'd1);
    $display("handshake: second result_hi=%08h lat=%0d", result_hi, n);

    // Reset mid-operation aborts with no done and a cleared result
    @(negedge clk);
    start = 1'b1; op = 2'b11; src1 = 32'h87654321; src2 = 32'h13579BDF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort result", 64'(result_hi), 64'd0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    $display("reset abort: done pulses after abort=%0d", ndone);
    run_op(2'b11, 32'h87654321, 32'h13579BDF, "post_reset");

    // Randomized ops, mixing in corner values
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        2: a = 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op(o, a, b, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
